// File: rtl/pattern_gen_core.sv
// rtl/pattern_gen_core.sv - line/frame test-pattern generator on a valid/ready pixel stream
// Optional feature: define PATGEN_RAMP_SAT_EN for saturating ramp arithmetic (wraps otherwise).
module pattern_gen_core #(
  parameter int PIX_W       = 12,
  parameter int LINE_LEN    = 1290,
  parameter int FRAME_LINES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_sync,
  input  logic             sync,
  input  logic [2:0]       mode,
  input  logic [PIX_W-1:0] const_val,
  input  logic [1:0]       cb_log2,
  input  logic             cb_invert,
  input  logic [PIX_W-1:0] dx,
  input  logic [PIX_W-1:0] dy,
  input  logic             pix_ready,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_sol,
  output logic             pix_eol,
  output logic             pix_eof,
  output logic             busy,
  output logic             err_mode
);

  localparam int X_W = $clog2(LINE_LEN);
  localparam int Y_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_LEN - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_LINES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_START  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  localparam logic [2:0] M_GRAY  = 3'b001;
  localparam logic [2:0] M_CONST = 3'b010;
  localparam logic [2:0] M_CB    = 3'b011;
  localparam logic [2:0] M_RAMP  = 3'b100;

  // Ramp accumulation step: clamps at all-ones when saturation is enabled.
  function automatic logic [PIX_W-1:0] ramp_add(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
`ifdef PATGEN_RAMP_SAT_EN
    logic [PIX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PIX_W] ? {PIX_W{1'b1}} : s[PIX_W-1:0];
`else
    return a + b;
`endif
  endfunction

  logic [1:0]       state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [2:0]       mode_q, mode_d;
  logic [PIX_W-1:0] cval_q, cval_d;
  logic [1:0]       cb_log2_q, cb_log2_d;
  logic             cb_inv_q, cb_inv_d;
  logic [PIX_W-1:0] dx_q, dx_d;
  logic [PIX_W-1:0] dy_q, dy_d;
  logic [PIX_W-1:0] base_q, base_d;
  logic [PIX_W-1:0] acc_q, acc_d;
  logic             valid_q, valid_d;
  logic [PIX_W-1:0] data_q, data_d;
  logic             sol_q, sol_d;
  logic             eol_q, eol_d;
  logic             eof_q, eof_d;
  logic             err_q, err_d;

  logic             in_start;
  logic             xfer;
  logic [2:0]       c_mode;
  logic [PIX_W-1:0] c_cval;
  logic [1:0]       c_log2;
  logic             c_inv;
  logic             mode_ok;
  logic [X_W-1:0]   nx;
  logic [PIX_W-1:0] nramp;
  logic [PIX_W-1:0] gray_b;
  logic             cb_bit;
  logic [PIX_W-1:0] npix;

  assign in_start = (state_q == S_START);
  assign xfer     = valid_q & pix_ready;

  // Value of the next pixel to present: in START it is pixel 0 from the raw config inputs,
  // otherwise the pixel after the current one using the latched config.
  always_comb begin
    c_mode  = in_start ? mode      : mode_q;
    c_cval  = in_start ? const_val : cval_q;
    c_log2  = in_start ? cb_log2   : cb_log2_q;
    c_inv   = in_start ? cb_invert : cb_inv_q;
    mode_ok = (c_mode >= M_GRAY) && (c_mode <= M_RAMP);
    nx      = in_start ? '0 : x_q + X_W'(1);
    nramp   = in_start ? base_q : ramp_add(acc_q, dx_q);
    gray_b  = PIX_W'(nx);
    cb_bit  = ((((nx >> c_log2) ^ X_W'(y_q >> c_log2)) & X_W'(1)) != '0) ^ c_inv;
    case (c_mode)
      M_GRAY:  npix = gray_b ^ (gray_b >> 1);
      M_CONST: npix = c_cval;
      M_CB:    npix = {PIX_W{cb_bit}};
      M_RAMP:  npix = nramp;
      default: npix = '0;
    endcase
  end

  // Line/frame sequencing FSM and output-register next state.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    mode_d    = mode_q;
    cval_d    = cval_q;
    cb_log2_d = cb_log2_q;
    cb_inv_d  = cb_inv_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    base_d    = base_q;
    acc_d     = acc_q;
    valid_d   = valid_q;
    data_d    = data_q;
    sol_d     = sol_q;
    eol_d     = eol_q;
    eof_d     = eof_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (f_sync && sync) begin
          state_d = S_START;
          y_d     = '0;
          base_d  = '0;
        end
      end
      S_START: begin
        mode_d    = mode;
        cval_d    = const_val;
        cb_log2_d = cb_log2;
        cb_inv_d  = cb_invert;
        dx_d      = dx;
        dy_d      = dy;
        x_d       = '0;
        if (!mode_ok) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ACTIVE;
          valid_d = 1'b1;
          data_d  = npix;
          acc_d   = nramp;
          sol_d   = 1'b1;
          eol_d   = 1'b0;
          eof_d   = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (xfer && (x_q == X_LAST)) begin
          valid_d = 1'b0;
          sol_d   = 1'b0;
          eol_d   = 1'b0;
          eof_d   = 1'b0;
          if (y_q == Y_LAST) begin
            state_d = S_IDLE;
          end else begin
            y_d     = y_q + Y_W'(1);
            base_d  = ramp_add(base_q, dy_q);
            state_d = sync ? S_START : S_WAIT;
          end
          if (f_sync && sync) begin
            state_d = S_START;
            y_d     = '0;
            base_d  = '0;
          end
        end else if (sync) begin
          // Mid-line sync abandons the line without emitting eol/eof.
          valid_d = 1'b0;
          sol_d   = 1'b0;
          eol_d   = 1'b0;
          eof_d   = 1'b0;
          state_d = S_START;
          if (f_sync) begin
            y_d    = '0;
            base_d = '0;
          end
        end else if (xfer) begin
          x_d    = nx;
          data_d = npix;
          acc_d  = nramp;
          sol_d  = 1'b0;
          eol_d  = (nx == X_LAST);
          eof_d  = (nx == X_LAST) && (y_q == Y_LAST);
        end
      end
      S_WAIT: begin
        if (sync) begin
          state_d = S_START;
          if (f_sync) begin
            y_d    = '0;
            base_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      mode_q    <= '0;
      cval_q    <= '0;
      cb_log2_q <= '0;
      cb_inv_q  <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      base_q    <= '0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      sol_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      mode_q    <= mode_d;
      cval_q    <= cval_d;
      cb_log2_q <= cb_log2_d;
      cb_inv_q  <= cb_inv_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      base_q    <= base_d;
      acc_q     <= acc_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      sol_q     <= sol_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
      err_q     <= err_d;
    end
  end

  assign pix_valid = valid_q;
  assign pix_data  = data_q;
  assign pix_sol   = sol_q;
  assign pix_eol   = eol_q;
  assign pix_eof   = eof_q;
  assign busy      = (state_q != S_IDLE);
  assign err_mode  = err_q;

endmodule

// File: tb/tb_pattern_gen_core.sv
// tb/tb_pattern_gen_core.sv - directed-vector bench for pattern_gen_core (PIX_W=4, LINE_LEN=8, FRAME_LINES=2)
module tb_pattern_gen_core;

  logic       clk;
  logic       rst;
  logic       f_sync;
  logic       sync;
  logic [2:0] mode;
  logic [3:0] const_val;
  logic [1:0] cb_log2;
  logic       cb_invert;
  logic [3:0] dx;
  logic [3:0] dy;
  logic       pix_ready;
  logic       pix_valid;
  logic [3:0] pix_data;
  logic       pix_sol;
  logic       pix_eol;
  logic       pix_eof;
  logic       busy;
  logic       err_mode;

  int n_vec;
  int n_bad;

  logic [31:0] cap_w;
  logic [7:0]  cap_sol;
  logic [7:0]  cap_eol;
  logic [7:0]  cap_eof;
  int          cap_n;

`ifdef PATGEN_RAMP_SAT_EN
  localparam logic [31:0] RAMP_L0 = 32'h0369CFFF;
  localparam logic [31:0] RAMP_L1 = 32'h58BEFFFF;
`else
  localparam logic [31:0] RAMP_L0 = 32'h0369CF25;
  localparam logic [31:0] RAMP_L1 = 32'h58BE147A;
`endif

  pattern_gen_core #(
    .PIX_W(4),
    .LINE_LEN(8),
    .FRAME_LINES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .f_sync(f_sync),
    .sync(sync),
    .mode(mode),
    .const_val(const_val),
    .cb_log2(cb_log2),
    .cb_invert(cb_invert),
    .dx(dx),
    .dy(dy),
    .pix_ready(pix_ready),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_sol(pix_sol),
    .pix_eol(pix_eol),
    .pix_eof(pix_eof),
    .busy(busy),
    .err_mode(err_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    f_sync = 1'b1;
    sync   = 1'b1;
    tick();
    f_sync = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic line_pulse();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  task automatic cap_clear();
    cap_w   = '0;
    cap_sol = '0;
    cap_eol = '0;
    cap_eof = '0;
    cap_n   = 0;
  endtask

  task automatic record_beat();
    if (pix_valid && pix_ready) begin
      cap_w = {cap_w[27:0], pix_data};
      cap_sol[cap_n] = pix_sol;
      cap_eol[cap_n] = pix_eol;
      cap_eof[cap_n] = pix_eof;
      cap_n++;
    end
  endtask

  task automatic get_line(input int nb);
    cap_clear();
    for (int c = 0; c < 100 && cap_n < nb; c++) begin
      record_beat();
      tick();
    end
    check_vec("beat_count", cap_n, nb);
  endtask

  task automatic check_line(input string tag, input logic [31:0] d, input logic [7:0] eof_m);
    check_vec({tag, "_data"}, cap_w, d);
    check_vec({tag, "_sol"}, cap_sol, 8'h01);
    check_vec({tag, "_eol"}, cap_eol, 8'h80);
    check_vec({tag, "_eof"}, cap_eof, eof_m);
  endtask

  initial begin
    int st4, st7, errs, seen_valid;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    f_sync = 1'b0;
    sync = 1'b0;
    mode = 3'b001;
    const_val = 4'h0;
    cb_log2 = 2'd0;
    cb_invert = 1'b0;
    dx = 4'h0;
    dy = 4'h0;
    pix_ready = 1'b1;
    tick();
    tick();
    check_vec("reset_outs", {pix_valid, pix_data, pix_sol, pix_eol, pix_eof, busy, err_mode}, 0);
    rst = 1'b0;
    tick();

    // Gray frame: two lines, eof on the last beat of line 1, busy then drops.
    mode = 3'b001;
    frame_pulse();
    check_vec("start_busy", busy, 1);
    check_vec("start_valid", pix_valid, 0);
    tick();
    check_vec("first_valid", pix_valid, 1);
    check_vec("first_sol", pix_sol, 1);
    get_line(8);
    check_line("gray_l0", 32'h01326754, 8'h00);
    check_vec("wait_busy", busy, 1);
    line_pulse();
    get_line(8);
    check_line("gray_l1", 32'h01326754, 8'h80);
    check_vec("eof_busy", busy, 0);
    check_vec("eof_valid", pix_valid, 0);

    // Checkerboard, cell edge 2, then inverted.
    mode = 3'b011;
    cb_log2 = 2'd1;
    cb_invert = 1'b0;
    frame_pulse();
    get_line(8);
    check_vec("cb_l0", cap_w, 32'h00FF00FF);
    line_pulse();
    get_line(8);
    check_line("cb_l1", 32'h00FF00FF, 8'h80);
    cb_invert = 1'b1;
    frame_pulse();
    get_line(8);
    check_vec("cb_inv_l0", cap_w, 32'hFF00FF00);

    // Ramp, frame restarted from WAIT.
    mode = 3'b100;
    dx = 4'd3;
    dy = 4'd5;
    frame_pulse();
    get_line(8);
    check_line("ramp_l0", RAMP_L0, 8'h00);
    line_pulse();
    get_line(8);
    check_line("ramp_l1", RAMP_L1, 8'h80);

    // Backpressure: stall on beat 4 (3 cycles) and on the eol beat (2 cycles).
    mode = 3'b010;
    const_val = 4'hA;
    frame_pulse();
    cap_clear();
    st4 = 0;
    st7 = 0;
    for (int c = 0; c < 100 && cap_n < 8; c++) begin
      if (pix_valid && cap_n == 4 && st4 < 3) begin
        pix_ready = 1'b0;
        st4++;
        check_vec("bp_hold4_data", pix_data, 4'hA);
        check_vec("bp_hold4_eol", pix_eol, 0);
      end else if (pix_valid && cap_n == 7 && st7 < 2) begin
        pix_ready = 1'b0;
        st7++;
        check_vec("bp_hold7_data", pix_data, 4'hA);
        check_vec("bp_hold7_eol", pix_eol, 1);
      end else begin
        pix_ready = 1'b1;
      end
      record_beat();
      tick();
    end
    pix_ready = 1'b1;
    check_vec("bp_count", cap_n, 8);
    check_vec("bp_data", cap_w, 32'hAAAAAAAA);
    check_vec("bp_eol", cap_eol, 8'h80);
    seen_valid = 0;
    for (int c = 0; c < 5; c++) begin
      if (pix_valid) seen_valid++;
      tick();
    end
    check_vec("bp_no_extra", seen_valid, 0);

    // Abort: sync while beat 3 is presented restarts line 0 without eol.
    mode = 3'b001;
    frame_pulse();
    get_line(3);
    check_vec("abort_part", cap_w, 32'h00000013);
    check_vec("abort_part_eol", cap_eol, 8'h00);
    pix_ready = 1'b0;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    pix_ready = 1'b1;
    check_vec("abort_valid", pix_valid, 0);
    check_vec("abort_eol", pix_eol, 0);
    get_line(8);
    check_line("abort_l0", 32'h01326754, 8'h00);
    line_pulse();
    get_line(8);
    check_line("abort_l1", 32'h01326754, 8'h80);

    // Invalid mode: one err_mode pulse, never a valid pixel.
    mode = 3'b111;
    frame_pulse();
    errs = 0;
    seen_valid = 0;
    for (int c = 0; c < 6; c++) begin
      if (err_mode) errs++;
      if (pix_valid) seen_valid++;
      tick();
    end
    check_vec("inv_err_pulses", errs, 1);
    check_vec("inv_valid", seen_valid, 0);
    check_vec("inv_busy", busy, 0);

    // Reset mid-line, then a clean frame from y=0.
    mode = 3'b010;
    const_val = 4'hA;
    frame_pulse();
    get_line(5);
    check_vec("rst_pre_valid", pix_valid, 1);
    rst = 1'b1;
    tick();
    check_vec("rst_mid_outs", {pix_valid, pix_data, pix_sol, pix_eol, pix_eof, busy, err_mode}, 0);
    rst = 1'b0;
    mode = 3'b001;
    frame_pulse();
    get_line(8);
    check_line("post_rst_l0", 32'h01326754, 8'h00);
    line_pulse();
    get_line(8);
    check_line("post_rst_l1", 32'h01326754, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_gen_core.md
# pattern_gen_core

Parametrised test-pattern generator that sequences lines and frames and emits pixels over a valid/ready stream. It generalises the existing fixed 12-bit, 1290-pixel pattern control with parametrised pixel width, line length and frame height, and adds programmable checkerboard cell size, ramp start/step values, backpressure and invalid-mode reporting. It sits between the sync/mode front end and the pixel sink.

## Interface
- PIX_W, 12, pixel width in bits
- LINE_LEN, 1290, pixels per line (≥2)
- FRAME_LINES, 1024, lines per frame (≥1)
- clk  input  1  master clock
- rst  input  1  asynchronous reset, active-high
- f_sync  input  1  frame sync qualifier
- sync  input  1  line start strobe
- mode  input  3  001 gray count, 010 constant, 011 checkerboard, 100 ramp; others invalid
- const_val  input  PIX_W  constant-mode pixel value
- cb_log2  input  2  checkerboard cell edge = 2^cb_log2 pixels/lines
- cb_invert  input  1  swap black/white cells
- dx  input  PIX_W  ramp step between columns
- dy  input  PIX_W  ramp step between rows
- pix_ready  input  1  sink accepts pixel
- pix_valid  output  1  pixel available
- pix_data  output  PIX_W  pixel value
- pix_sol  output  1  first pixel of line (qualified by pix_valid)
- pix_eol  output  1  last pixel of line (qualified by pix_valid)
- pix_eof  output  1  last pixel of frame (qualified by pix_valid)
- busy  output  1  state ≠ IDLE
- err_mode  output  1  one-cycle pulse: invalid mode latched in START

## Operation
- States: IDLE, START, ACTIVE, WAIT.
- IDLE: f_sync & sync → START, y=0.
- START (1 cycle): latch mode, const_val, cb_log2, cb_invert, dx, dy; x=0. Invalid mode → err_mode=1, go IDLE. Otherwise → ACTIVE.
- ACTIVE: pix_valid=1; a beat transfers on pix_valid & pix_ready; x increments per beat.
- Last beat (x=LINE_LEN-1): if y=FRAME_LINES-1 → IDLE, pix_eof=1 on that beat; else y++ → WAIT.
- WAIT: sync → START (x=0, y kept); f_sync & sync → START with y=0.
- Pixel values (x, y are line/column indices, mod 2^PIX_W arithmetic):
  - gray: b = x mod 2^PIX_W; data = b ^ (b>>1).
  - constant: const_val.
  - checkerboard: c = ((x>>cb_log2) ^ (y>>cb_log2)) & 1 ^ cb_invert; data = c ? all-ones : 0.
  - ramp: line base = y·dy, accumulated per line at line end; data = base + x·dx, accumulated per beat.
- Boundaries:
  - sync in ACTIVE mid-line aborts the line: → START, same y, no eol/eof emitted.
  - f_sync & sync in ACTIVE restart the frame: y=0, ramp base=0.
  - Final-beat transfer coinciding with sync, not last line → START directly, skipping WAIT.
  - Final-beat transfer coinciding with sync on the last line → IDLE. The sync is not re-sampled there unless f_sync is also set, which → START with y=0.
  - Config inputs change only take effect at the next START.
  - Asynchronous rst at any point → IDLE immediately, all counters 0.

## Timing
- Reset values: pix_valid, pix_data, pix_sol, pix_eol, pix_eof, busy, err_mode all 0; state IDLE; x, y, ramp base 0.
- sync sampled at edge N in IDLE/WAIT → START during cycle N+1 → first pix_valid in cycle N+2.
- While pix_valid & !pix_ready, pix_data, pix_sol, pix_eol and pix_eof are held stable.
- Throughput: one pixel per cycle under continuous pix_ready.
- Outputs are registered; the first pixel value is computed in START.
- busy rises in START and falls in the cycle after the eof beat transfers.

## Configuration
- PATGEN_RAMP_SAT_EN defined: ramp pixel and line-base accumulation saturate at 2^PIX_W-1 and stay there for the rest of the line/frame.
- PATGEN_RAMP_SAT_EN undefined: ramp arithmetic wraps modulo 2^PIX_W.
- No other mode is affected by the macro.

## Test plan
Bench uses PIX_W=4, LINE_LEN=8, FRAME_LINES=2, pix_ready=1 unless stated.
- Gray: mode=001, f_sync & sync pulse → data 0,1,3,2,6,7,5,4. sol on beat 0, eol on beat 7. After sync: line 2 repeats the sequence with eof on its last beat; busy falls.
- Checkerboard: mode=011, cb_log2=1, cb_invert=0 → line0 data 0,0,F,F,0,0,F,F; line1 identical. With cb_invert=1, line0 = F,F,0,0,F,F,0,0.
- Ramp wrap: mode=100, dx=3, dy=5 → line0 0,3,6,9,C,F,2,5; line1 5,8,B,E,1,4,7,A. With PATGEN_RAMP_SAT_EN, line0 0,3,6,9,C,F,F,F.
- Backpressure: constant mode, const_val=A, pix_ready low for 3 cycles on beat 4 → data/eol held. Exactly 8 transfers; eol only on the 8th.
- Abort/invalid: sync on beat 3 of line0 → restart line0 with no eol. Separately, mode=111 → one err_mode pulse, back to IDLE, pix_valid never asserted.
- Reset mid-line: rst on beat 5 → all outputs 0 next cycle; a new f_sync & sync starts at y=0.
